// File: rtl/rx_ring_pkg.sv
// Shared widths, pointer type and read-FSM encoding for the RX_RING controller.
package rx_ring_pkg;
    localparam int ADDR_WIDTH        = 5;
    localparam int DATA_WIDTH        = 48;
    localparam int BE_WIDTH          = DATA_WIDTH / 8;
    localparam int DEPTH             = 2 ** ADDR_WIDTH;
    localparam int PTR_W             = ADDR_WIDTH + 1;
    localparam int AFULL_THRESH_DFLT = 28;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2
    } rd_state_t;

    // Extra MSB distinguishes full from empty when the address bits match.
    typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/rx_ring_ctrl_if.sv
// Valid/ready stream bundle: input words into the ring and registered output words.
interface rx_ring_ctrl_if;
    import rx_ring_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [BE_WIDTH-1:0]   in_be;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_be, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_be, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/rx_ring_ctrl.sv
// Ring-buffer FIFO controller sequencing the RX_RING RAM; one word per two cycles on the read side.
// Defining RX_RING_CTRL_DROP_EN keeps in_ready high and counts words discarded while full.
module rx_ring_ctrl
    import rx_ring_pkg::*;
#(
    parameter int AFULL_THRESH = AFULL_THRESH_DFLT
) (
    input  logic                  wr_clk,
    input  logic                  tb_wr_rst,
    input  logic                  flush,
    rx_ring_ctrl_if.slave         s,
    output logic [PTR_W-1:0]      level,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [15:0]           drop_cnt,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);
    ptr_t                  wr_ptr_reg;
    ptr_t                  rd_ptr_reg;
    rd_state_t             state_reg;
    rd_state_t             state_next;
    logic                  out_valid_reg;
    logic                  out_valid_next;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  load_en;
    logic                  wr_fire;

    assign level       = wr_ptr_reg - rd_ptr_reg;
    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]) &&
                         (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]);
    assign almost_full = (level >= PTR_W'(AFULL_THRESH));

`ifdef RX_RING_CTRL_DROP_EN
    logic        drop_fire;
    logic [15:0] drop_cnt_reg;

    assign s.in_ready = !flush;
    assign wr_fire    = s.in_valid && !flush && !full;
    assign drop_fire  = s.in_valid && !flush && full;

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            drop_cnt_reg <= '0;
        end else if (drop_fire && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end
    assign drop_cnt = drop_cnt_reg;
`else
    assign s.in_ready = !flush && !full;
    assign wr_fire    = s.in_valid && !flush && !full;
    assign drop_cnt   = '0;
`endif

    // Write command is combinational so the RAM commits on the same edge wr_ptr advances.
    assign ram_wr_en      = wr_fire;
    assign ram_wr_addr    = wr_ptr_reg[ADDR_WIDTH-1:0];
    assign ram_wr_data    = s.in_data;
    assign ram_wr_byte_en = s.in_be;
    assign ram_rd_addr    = rd_ptr_reg[ADDR_WIDTH-1:0];

    assign s.out_valid = out_valid_reg;
    assign s.out_data  = out_data_reg;

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (!empty) state_next = S_LOAD;
            S_LOAD:  state_next = S_HOLD;
            S_HOLD:  if (s.out_ready) state_next = empty ? S_IDLE : S_LOAD;
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    // out_valid stays high through a back-to-back reload; it only drops when the ring runs dry.
    always_comb begin
        load_en        = 1'b0;
        out_valid_next = out_valid_reg;
        if (flush) begin
            out_valid_next = 1'b0;
        end else begin
            case (state_reg)
                S_LOAD: begin
                    load_en        = 1'b1;
                    out_valid_next = 1'b1;
                end
                S_HOLD:  if (s.out_ready && empty) out_valid_next = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (wr_fire) begin
                    wr_ptr_reg <= wr_ptr_reg + ptr_t'(1);
                end
                if (load_en) begin
                    rd_ptr_reg   <= rd_ptr_reg + ptr_t'(1);
                    out_data_reg <= ram_rd_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_ring_ctrl.sv
// Self-checking bench for rx_ring_ctrl with a byte-enabled RAM model and a queue-based scoreboard.
`timescale 1ns/1ps
module tb_rx_ring_ctrl;
    import rx_ring_pkg::*;

    logic                  wr_clk = 1'b0;
    logic                  tb_wr_rst = 1'b1;
    logic                  flush = 1'b0;
    logic [PTR_W-1:0]      level;
    logic                  empty, full, almost_full;
    logic [15:0]           drop_cnt;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_wr_addr, ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic [DATA_WIDTH-1:0] ram_rd_data = '0;
    logic [BE_WIDTH-1:0]   ram_wr_byte_en;

    rx_ring_ctrl_if rif();

    rx_ring_ctrl dut (
        .wr_clk         (wr_clk),
        .tb_wr_rst      (tb_wr_rst),
        .flush          (flush),
        .s              (rif.slave),
        .level          (level),
        .empty          (empty),
        .full           (full),
        .almost_full    (almost_full),
        .drop_cnt       (drop_cnt),
        .ram_wr_en      (ram_wr_en),
        .ram_wr_addr    (ram_wr_addr),
        .ram_wr_data    (ram_wr_data),
        .ram_wr_byte_en (ram_wr_byte_en),
        .ram_rd_addr    (ram_rd_addr),
        .ram_rd_data    (ram_rd_data)
    );

    always #5 wr_clk = ~wr_clk;

    // RX_RING stand-in: byte-enabled write, read data valid the cycle after the address is sampled.
    logic [DATA_WIDTH-1:0] ram_mem [DEPTH] = '{default: '0};
    always @(posedge wr_clk) begin
        if (ram_wr_en) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (ram_wr_byte_en[b]) ram_mem[ram_wr_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
            end
        end
        ram_rd_data <= ram_mem[ram_rd_addr];
    end

    // Reference model: slot contents, queue of words in flight, and word counts.
    logic [DATA_WIDTH-1:0] slot_m [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] q[$];
    int total = 0;
    int wr_count = 0;
    int drops = 0;
    bit skip = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        total = 0;
        wr_count = 0;
        drops = 0;
        skip = 1'b0;
    endtask

    // One clock: drive inputs at negedge, check against the model, update it, return at posedge+1.
    task automatic cycle(input bit fl, input bit iv, input logic [DATA_WIDTH-1:0] d,
                         input logic [BE_WIDTH-1:0] be, input bit ordy);
        int exp_lvl;
        bit exp_full, exp_rdy, wr, xfer, drop;
        logic [DATA_WIDTH-1:0] merged;
        @(negedge wr_clk);
        flush = fl;
        rif.in_valid = iv;
        rif.in_data = d;
        rif.in_be = be;
        rif.out_ready = ordy;
        #1;
        // A word sitting in out_data (not yet accepted) has left the RAM.
        exp_lvl = total - ((rif.out_valid && !skip) ? 1 : 0);
        exp_full = (exp_lvl == DEPTH);
`ifdef RX_RING_CTRL_DROP_EN
        exp_rdy = !fl;
`else
        exp_rdy = !fl && !exp_full;
`endif
        chk("level", level, exp_lvl);
        chk("empty", empty, exp_lvl == 0);
        chk("full", full, exp_full);
        chk("almost_full", almost_full, exp_lvl >= AFULL_THRESH_DFLT);
        chk("in_ready", rif.in_ready, exp_rdy);
        wr = iv && !fl && !exp_full;
        drop = iv && !fl && exp_full && exp_rdy;
        chk("ram_wr_en", ram_wr_en, wr);
        if (wr) chk("ram_wr_addr", ram_wr_addr, wr_count % DEPTH);
        chk("drop_cnt", drop_cnt, drops);
        xfer = rif.out_valid && ordy && !skip && !fl;
        if (fl) begin
            q.delete();
            total = 0;
            wr_count = 0;
            skip = 1'b0;
        end else begin
            if (xfer) begin
                chk("xfer_has_data", q.size() != 0, 1);
                if (q.size() != 0) begin
                    chk("out_data", rif.out_data, q[0]);
                    void'(q.pop_front());
                end
                total--;
            end
            if (wr) begin
                merged = slot_m[wr_count % DEPTH];
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (be[b]) merged[8*b +: 8] = d[8*b +: 8];
                end
                slot_m[wr_count % DEPTH] = merged;
                q.push_back(merged);
                wr_count++;
                total++;
            end
            if (drop && drops != 16'hFFFF) drops++;
            skip = xfer;
        end
        @(posedge wr_clk);
        #1;
    endtask

    task automatic drain(input int limit);
        int c;
        c = 0;
        while (total > 0 && c < limit) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b1);
            c++;
        end
        chk("drain_done_words_left", total, 0);
    endtask

    typedef struct {
        bit                    iv;
        logic [DATA_WIDTH-1:0] d;
        logic [BE_WIDTH-1:0]   be;
        bit                    ordy;
        bit                    e_ov;
        int                    e_lvl;
        bit                    e_empty;
        bit                    chk_d;
        logic [DATA_WIDTH-1:0] e_d;
    } vec_t;
    vec_t vt[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        vt[0] = '{1'b1, 48'hFFFF_FFFF_FFFF, 6'h3F, 1'b1, 1'b0, 1, 1'b0, 1'b0, 48'h0};
        vt[1] = '{1'b0, 48'h0, 6'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 48'h0};
        vt[2] = '{1'b0, 48'h0, 6'h00, 1'b1, 1'b1, 0, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFF};
        vt[3] = '{1'b0, 48'h0, 6'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 48'h0};
        vt[4] = '{1'b1, 48'h1234_5678_9ABC, 6'h3F, 1'b0, 1'b0, 1, 1'b0, 1'b0, 48'h0};
        vt[5] = '{1'b0, 48'h0, 6'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 48'h0};
        vt[6] = '{1'b0, 48'h0, 6'h00, 1'b0, 1'b1, 0, 1'b1, 1'b1, 48'h1234_5678_9ABC};
        vt[7] = '{1'b0, 48'h0, 6'h00, 1'b0, 1'b1, 0, 1'b1, 1'b1, 48'h1234_5678_9ABC};
        vt[8] = '{1'b0, 48'h0, 6'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 48'h0};

        rif.in_valid = 1'b0;
        rif.in_data = '0;
        rif.in_be = '0;
        rif.out_ready = 1'b0;
        repeat (3) @(posedge wr_clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_out_valid", rif.out_valid, 0);
        chk("rst_out_data", rif.out_data, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        @(negedge wr_clk);
        tb_wr_rst = 1'b0;
        model_reset();

        // Single words: out_valid two edges after the write, then a held word.
        foreach (vt[i]) begin
            cycle(1'b0, vt[i].iv, vt[i].d, vt[i].be, vt[i].ordy);
            chk($sformatf("tbl%0d_out_valid", i), rif.out_valid, vt[i].e_ov);
            chk($sformatf("tbl%0d_level", i), level, vt[i].e_lvl);
            chk($sformatf("tbl%0d_empty", i), empty, vt[i].e_empty);
            if (vt[i].chk_d) chk($sformatf("tbl%0d_out_data", i), rif.out_data, vt[i].e_d);
        end

        // Fill with consumer stalled: 33 words total (32 in RAM plus the held one).
        for (int i = 0; i < 33; i++) cycle(1'b0, 1'b1, 48'(1000 - i), 6'h3F, 1'b0);
        chk("fill_full", full, 1);
        chk("fill_level", level, 32);
        chk("fill_almost_full", almost_full, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 48'hDEAD_0000_0000 + 48'(i), 6'h3F, 1'b0);
`ifdef RX_RING_CTRL_DROP_EN
        chk("drop_in_ready", rif.in_ready, 1);
        chk("drop_cnt_3", drop_cnt, 3);
`else
        chk("nodrop_in_ready", rif.in_ready, 0);
        chk("nodrop_drop_cnt", drop_cnt, 0);
`endif
        chk("fill_level_after_offer", level, 32);

        // Drain while topping up to 64 writes: pointers wrap, one word per two cycles.
        cyc = 0;
        while (total > 0 && cyc < 200) begin
            cycle(1'b0, wr_count < 64, 48'(5000 + wr_count), 6'h3F, 1'b1);
            cyc++;
        end
        chk("wrap_drained", total, 0);
        chk("wrap_throughput_ok", cyc <= 130, 1);

        // Flush with 10 words stored; the flush cycle must not accept its own word.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 48'(200 + i), 6'h3F, 1'b0);
        cycle(1'b1, 1'b1, 48'hBAD0_BAD0_BAD0, 6'h3F, 1'b0);
        chk("flush_level", level, 0);
        chk("flush_empty", empty, 1);
        chk("flush_out_valid", rif.out_valid, 0);
        cycle(1'b0, 1'b1, 48'hCAFE_F00D_BEEF, 6'h3F, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        chk("post_flush_data", rif.out_data, 48'hCAFE_F00D_BEEF);
        drain(20);

        // Randomized traffic with occasional flushes and partial byte enables.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6,
                  {16'($urandom), 32'($urandom)},
                  ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F,
                  $urandom_range(0, 1) == 1);
        end
        drain(100);

        // Partial byte enable over a slot holding zero.
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b1, 48'h0, 6'h3F, 1'b0);
        drain(10);
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b1, 48'hAAAA_AAAA_AAAA, 6'h01, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        chk("be_valid", rif.out_valid, 1);
        chk("be_merge", rif.out_data, 48'h0000_0000_00AA);
        drain(10);

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 48'(300 + i), 6'h3F, 1'b0);
        @(negedge wr_clk);
        rif.in_valid = 1'b0;
        #2;
        tb_wr_rst = 1'b1;
        #1;
        chk("arst_level", level, 0);
        chk("arst_empty", empty, 1);
        chk("arst_out_valid", rif.out_valid, 0);
        chk("arst_drop_cnt", drop_cnt, 0);
        @(negedge wr_clk);
        tb_wr_rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b1, 48'h0BAD_C0DE_1234, 6'h3F, 1'b1);
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
